// File: rtl/ft601_pkg.sv
// Shared types and defaults for the FT601 245-mode bus scheduler.
package ft601_pkg;

    // Default bus geometry of the FT601 in 32-bit mode
    localparam int WIDTH_DATA_DEF = 32;
    localparam int CNT_BE_DEF     = WIDTH_DATA_DEF / 8;

    // Scheduler states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_OE   = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        TURN    = 3'd4
    } state_t;

    // Direction of the most recent burst, used for fair alternation
    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_t;

endpackage

// File: rtl/ft601_245_bus_sched.sv
// Master-side scheduler for the FT601 245 FIFO bus: arbitrates the shared
// half-duplex bus between host reads and host writes, drives the strobes,
// inserts a turnaround cycle between directions and caps burst length.
module ft601_245_bus_sched
    import ft601_pkg::*;
#(
    parameter int WIDTH_DATA = WIDTH_DATA_DEF,
    parameter int CNT_BE     = CNT_BE_DEF,
    parameter int MAX_BURST  = 256
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RXF_N,
    input  logic                  TXE_N,
    input  logic [WIDTH_DATA-1:0] DATA_IN,
    input  logic [CNT_BE-1:0]     BE_IN,
    output logic [WIDTH_DATA-1:0] DATA_OUT,
    output logic [CNT_BE-1:0]     BE_OUT,
    output logic                  DATA_OE,
    output logic                  WR_N,
    output logic                  RD_N,
    output logic                  OE_N,
    output logic                  SIWU_N,
    input  logic                  tx_valid,
    input  logic [WIDTH_DATA-1:0] tx_data,
    input  logic [CNT_BE-1:0]     tx_be,
    output logic                  tx_pop,
    input  logic                  rx_afull,
    output logic                  rx_valid,
    output logic [WIDTH_DATA-1:0] rx_data,
    output logic [CNT_BE-1:0]     rx_be,
    output logic                  busy,
    output logic                  rx_ovf
);

    localparam int BURST_W = $clog2(MAX_BURST);

    state_t             state;
    dir_t               last_dir;
    logic [BURST_W-1:0] cnt;
    logic [2:0]         afull_run;
    logic               rd_n_q;
    logic               oe_n_q;
    logic               data_oe_q;

    logic pend_rd;
    logic pend_wr;
    logic wr_active;
    logic capture;
    logic cnt_last;

    assign pend_rd   = !RXF_N && !rx_afull;
    assign pend_wr   = !TXE_N && tx_valid;
    // The write strobe follows the FIFO flag directly so a word is never
    // strobed unless it is really there; reset suppresses it immediately.
    assign wr_active = (state == WR_DATA) && tx_valid && !RST;
    assign capture   = (state == RD_DATA) && !rd_n_q && !RXF_N;
    assign cnt_last  = (cnt == BURST_W'(MAX_BURST - 1));

    assign WR_N     = !wr_active;
    assign tx_pop   = wr_active && !TXE_N;
    assign DATA_OUT = tx_data;
    assign BE_OUT   = tx_be;
    assign DATA_OE  = data_oe_q;
    assign RD_N     = rd_n_q;
    assign OE_N     = oe_n_q;
    assign SIWU_N   = 1'b1;
    assign busy     = (state != IDLE);

    // Bus state machine with registered strobes, burst counter and RX capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            last_dir  <= DIR_WR;
            cnt       <= '0;
            afull_run <= '0;
            rd_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            rx_be     <= '0;
            rx_ovf    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (capture) begin
                rx_valid <= 1'b1;
                rx_data  <= DATA_IN;
                rx_be    <= BE_IN;
            end

            if ((state == RD_OE || state == RD_DATA) && rx_afull) begin
                if (afull_run != 3'd4) begin
                    afull_run <= afull_run + 3'd1;
                end
            end else begin
                afull_run <= '0;
            end
            if (capture && rx_afull && (afull_run >= 3'd3)) begin
                rx_ovf <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pend_rd && (!pend_wr || last_dir == DIR_WR)) begin
                        state    <= RD_OE;
                        oe_n_q   <= 1'b0;
                        last_dir <= DIR_RD;
                        cnt      <= '0;
                    end else if (pend_wr) begin
                        state     <= WR_DATA;
                        data_oe_q <= 1'b1;
                        last_dir  <= DIR_WR;
                        cnt       <= '0;
                    end
                end
                RD_OE: begin
                    state  <= RD_DATA;
                    rd_n_q <= 1'b0;
                end
                RD_DATA: begin
                    if (capture && !cnt_last) begin
                        cnt <= cnt + BURST_W'(1);
                    end
                    if (RXF_N || rx_afull || (capture && cnt_last)) begin
                        state  <= TURN;
                        rd_n_q <= 1'b1;
                        oe_n_q <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (tx_pop && !cnt_last) begin
                        cnt <= cnt + BURST_W'(1);
                    end
                    if (TXE_N || !tx_valid || (tx_pop && cnt_last)) begin
                        state     <= TURN;
                        data_oe_q <= 1'b0;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    rd_n_q    <= 1'b1;
                    oe_n_q    <= 1'b1;
                    data_oe_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft601_245_bus_sched.sv
// Directed self-checking bench for the FT601 245-mode bus scheduler.
module tb_ft601_245_bus_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RXF_N;
    logic        TXE_N;
    logic [31:0] DATA_IN;
    logic [3:0]  BE_IN;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic [3:0]  tx_be;
    logic        rx_afull;

    logic [31:0] data_out, rx_data;
    logic [3:0]  be_out, rx_be;
    logic        data_oe, wr_n, rd_n, oe_n, siwu_n, tx_pop, rx_valid, busy, rx_ovf;

    logic [31:0] data_out_4, rx_data_4;
    logic [3:0]  be_out_4, rx_be_4;
    logic        data_oe_4, wr_n_4, rd_n_4, oe_n_4, siwu_n_4, tx_pop_4, rx_valid_4, busy_4, rx_ovf_4;

    int          checks = 0;
    int          failures = 0;
    bit          rd_model_on = 1'b0;
    int          rd_idx = 0;
    int          rd_total = 0;
    bit          tx_model_on = 1'b0;
    int          tx_idx = 0;
    int          tx_total = 0;
    logic        pop_pre;
    logic        pop4_pre;
    logic [31:0] popped[$];

    // Free-running 100 MHz bus clock
    always #5 CLK = ~CLK;

    ft601_245_bus_sched dut (
        .CLK(CLK), .RST(RST), .RXF_N(RXF_N), .TXE_N(TXE_N),
        .DATA_IN(DATA_IN), .BE_IN(BE_IN),
        .DATA_OUT(data_out), .BE_OUT(be_out), .DATA_OE(data_oe),
        .WR_N(wr_n), .RD_N(rd_n), .OE_N(oe_n), .SIWU_N(siwu_n),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_be(tx_be), .tx_pop(tx_pop),
        .rx_afull(rx_afull), .rx_valid(rx_valid), .rx_data(rx_data), .rx_be(rx_be),
        .busy(busy), .rx_ovf(rx_ovf)
    );

    ft601_245_bus_sched #(.MAX_BURST(4)) dut4 (
        .CLK(CLK), .RST(RST), .RXF_N(RXF_N), .TXE_N(TXE_N),
        .DATA_IN(DATA_IN), .BE_IN(BE_IN),
        .DATA_OUT(data_out_4), .BE_OUT(be_out_4), .DATA_OE(data_oe_4),
        .WR_N(wr_n_4), .RD_N(rd_n_4), .OE_N(oe_n_4), .SIWU_N(siwu_n_4),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_be(tx_be), .tx_pop(tx_pop_4),
        .rx_afull(rx_afull), .rx_valid(rx_valid_4), .rx_data(rx_data_4), .rx_be(rx_be_4),
        .busy(busy_4), .rx_ovf(rx_ovf_4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rxf, input logic txe, input logic valid, input logic afull);
        RXF_N    = rxf;
        TXE_N    = txe;
        tx_valid = valid;
        rx_afull = afull;
    endtask

    // One bus cycle: sample combinational outputs before the edge, advance
    // the host-side and TX FIFO models after it.
    task automatic step();
        logic rd_take;
        #2;
        pop_pre  = tx_pop;
        pop4_pre = tx_pop_4;
        rd_take  = !rd_n && !RXF_N;
        if (tx_model_on && tx_pop) popped.push_back(data_out);
        @(posedge CLK);
        #1;
        if (rd_model_on && rd_take) begin
            rd_idx++;
            DATA_IN = 32'(32'hA0 + rd_idx);
            if (rd_idx >= rd_total) RXF_N = 1'b1;
        end
        if (tx_model_on) begin
            if (pop_pre) tx_idx++;
            tx_data  = 32'(32'hB0 + tx_idx);
            tx_valid = (tx_idx < tx_total);
        end
    endtask

    task automatic applyReset();
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rxv[14];
        logic [31:0] popv[14];
        int          viol;
        int          caps;
        int          guard;

        RST = 1'b1;
        DATA_IN = 32'h0;
        BE_IN = 4'hF;
        tx_data = 32'h0;
        tx_be = 4'h3;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset held with everything pending
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rst_wr_n", wr_n, 1);
            checkOutput("rst_rd_n", rd_n, 1);
            checkOutput("rst_oe_n", oe_n, 1);
            checkOutput("rst_data_oe", data_oe, 0);
            checkOutput("rst_tx_pop", pop_pre, 0);
            checkOutput("rst_rx_valid", rx_valid, 0);
        end
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rx_ovf", rx_ovf, 0);
        checkOutput("rst_siwu", siwu_n, 1);

        // Read burst of three words
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyReset();
        rd_idx = 0; rd_total = 3; DATA_IN = 32'hA0; rd_model_on = 1'b1; RXF_N = 1'b0;
        step();
        checkOutput("rd_oe_oe_n", oe_n, 0);
        checkOutput("rd_oe_rd_n", rd_n, 1);
        step();
        checkOutput("rd_data_rd_n", rd_n, 0);
        checkOutput("rd_data_oe_n", oe_n, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rd_valid", rx_valid, 1);
            checkOutput("rd_word", rx_data, 32'hA0 + 32'(i));
        end
        checkOutput("rd_be", rx_be, 4'hF);
        step();
        checkOutput("rd_turn_valid", rx_valid, 0);
        checkOutput("rd_turn_rd_n", rd_n, 1);
        checkOutput("rd_turn_oe_n", oe_n, 1);
        checkOutput("rd_turn_busy", busy, 1);
        step();
        checkOutput("rd_idle_busy", busy, 0);
        rd_model_on = 1'b0;

        // Contention on the MAX_BURST=4 instance
        RST = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) step();
        RST = 1'b0;
        viol = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            rxv[k]  = 32'(rx_valid_4);
            popv[k] = 32'(pop4_pre);
            if (data_oe_4 && !oe_n_4) viol++;
        end
        for (int k = 0; k < 14; k++) begin
            checkOutput($sformatf("cont_rxv_%0d", k), rxv[k], 32'(k >= 2 && k <= 5));
            checkOutput($sformatf("cont_pop_%0d", k), popv[k], 32'(k >= 8 && k <= 11));
        end
        checkOutput("cont_rd_again_oe_n", oe_n_4, 0);
        checkOutput("cont_rd_again_data_oe", data_oe_4, 0);
        checkOutput("cont_bus_clash", viol, 0);

        // rx_afull raised after the second captured word
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyReset();
        rd_idx = 0; rd_total = 8; DATA_IN = 32'hA0; rd_model_on = 1'b1; RXF_N = 1'b0;
        repeat (4) step();
        checkOutput("afull_word2", rx_data, 32'hA1);
        rx_afull = 1'b1;
        caps = 0;
        step();
        checkOutput("afull_rd_n", rd_n, 1);
        if (rx_valid) caps++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rx_valid) caps++;
        end
        checkOutput("afull_caps_le2", 32'(caps <= 2), 1);
        checkOutput("afull_rx_ovf", rx_ovf, 0);
        checkOutput("afull_idle", busy, 0);
        checkOutput("afull_hold_rd_n", rd_n, 1);
        rd_model_on = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

        // TXE_N rises after five pops, then the write resumes
        tx_model_on = 1'b1; tx_idx = 0; tx_total = 10; tx_data = 32'hB0; tx_valid = 1'b1;
        popped.delete();
        applyReset();
        TXE_N = 1'b0;
        step();
        checkOutput("wr_data_oe", data_oe, 1);
        repeat (5) step();
        checkOutput("wr_pops_before_stall", popped.size(), 5);
        TXE_N = 1'b1;
        step();
        checkOutput("wr_stall_pop", pop_pre, 0);
        checkOutput("wr_turn_data_oe", data_oe, 0);
        checkOutput("wr_turn_busy", busy, 1);
        step();
        checkOutput("wr_idle_busy", busy, 0);
        repeat (2) step();
        TXE_N = 1'b0;
        guard = 0;
        while (tx_idx < 10 && guard < 40) begin
            step();
            guard++;
        end
        checkOutput("wr_resume_timeout", 32'(guard < 40), 1);
        repeat (2) step();
        checkOutput("wr_total_pops", popped.size(), 10);
        for (int i = 0; i < 10 && i < popped.size(); i++) begin
            checkOutput($sformatf("wr_word_%0d", i), popped[i], 32'hB0 + 32'(i));
        end

        // Reset in the middle of a write burst
        TXE_N = 1'b1;
        tx_idx = 0; tx_total = 10; tx_data = 32'hB0; tx_valid = 1'b1;
        popped.delete();
        applyReset();
        TXE_N = 1'b0;
        repeat (3) step();
        checkOutput("mid_rst_pops", popped.size(), 2);
        RST = 1'b1;
        step();
        checkOutput("mid_rst_no_pop", pop_pre, 0);
        checkOutput("mid_rst_wr_n", wr_n, 1);
        checkOutput("mid_rst_data_oe", data_oe, 0);
        checkOutput("mid_rst_busy", busy, 0);
        RST = 1'b0;
        RXF_N = 1'b0;
        step();
        checkOutput("mid_rst_rd_first_oe_n", oe_n, 0);
        checkOutput("mid_rst_rd_first_data_oe", data_oe, 0);
        tx_model_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
